// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer driving one external 1-bit full-adder slice.
// Latency: WIDTH+1 edges from accepted start to the done cycle; issue interval WIDTH+1.
// Backpressure: none; start is only accepted in IDLE/DONE and dropped (not queued) while busy.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic             cout_r;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Capture the slice result for the bit currently presented, then advance.
                    sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                    carry  <= fa_co;
                    cout_r <= fa_co;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Slice inputs come straight from flops so they are stable for the whole cycle.
    assign fa_a  = a_sr[0];
    assign fa_b  = b_sr[0];
    assign fa_ci = carry;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign sum  = sum_sr;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: behavioural full-adder slice plus arithmetic reference of a+b+cin.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       fa_a;
    logic       fa_b;
    logic       fa_ci;
    logic       fa_s;
    logic       fa_co;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (op_a),
        .b     (op_b),
        .cin   (op_cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .fa_a  (fa_a),
        .fa_b  (fa_b),
        .fa_ci (fa_ci),
        .fa_s  (fa_s),
        .fa_co (fa_co)
    );

    // External slice: plain truth-table full adder.
    assign fa_s  = fa_a ^ fa_b ^ fa_ci;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  16'(busy),  16'd0);
        chk({tag, "_done"},  16'(done),  16'd0);
        chk({tag, "_sum"},   16'(sum),   16'd0);
        chk({tag, "_cout"},  16'(cout),  16'd0);
        chk({tag, "_fa_a"},  16'(fa_a),  16'd0);
        chk({tag, "_fa_b"},  16'(fa_b),  16'd0);
        chk({tag, "_fa_ci"}, 16'(fa_ci), 16'd0);
    endtask

    // One complete add, observed at negedges. preloaded: operands/start already driven
    // during the previous DONE cycle. chain: drive the next operands with start in this DONE cycle.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                           input bit preloaded, input bit keep_start, input bit stray,
                           input bit chain, input logic [7:0] na, input logic [7:0] nb,
                           input logic nc);
        logic [8:0] expv;
        logic [8:0] part;
        logic [7:0] m;
        expv = {1'b0, ta} + {1'b0, tbv} + {8'd0, tc};
        if (!preloaded) begin
            @(negedge clk);
            op_a = ta; op_b = tbv; op_cin = tc; start = 1'b1;
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            start  = keep_start || (stray && i == 2);
            op_a   = (stray && i == 2) ? 8'h11 : 8'($urandom);
            op_b   = 8'($urandom);
            op_cin = 1'($urandom);
            chk("run_busy", 16'(busy), 16'd1);
            chk("run_done", 16'(done), 16'd0);
            chk("run_fa_a", 16'(fa_a), 16'(ta[i]));
            chk("run_fa_b", 16'(fa_b), 16'(tbv[i]));
            m    = 8'((9'd1 << i) - 9'd1);
            part = {1'b0, ta & m} + {1'b0, tbv & m} + {8'd0, tc};
            chk("run_fa_ci", 16'(fa_ci), 16'(part[i]));
            @(negedge clk);
        end
        chk("done_pulse", 16'(done), 16'd1);
        chk("done_busy",  16'(busy), 16'd0);
        chk("done_sum",   16'(sum),  16'(expv[7:0]));
        chk("done_cout",  16'(cout), 16'(expv[8]));
        if (chain) begin
            op_a = na; op_b = nb; op_cin = nc; start = 1'b1;
        end else begin
            start = 1'b0;
            @(negedge clk);
            chk("idle_done", 16'(done), 16'd0);
            chk("idle_busy", 16'(busy), 16'd0);
            chk("idle_sum",  16'(sum),  16'(expv[7:0]));
            chk("idle_cout", 16'(cout), 16'(expv[8]));
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        rst_n = 1'b0; start = 1'b0; op_a = 8'h00; op_b = 8'h00; op_cin = 1'b0;
        #25;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_add(8'h5A, 8'h3C, 1'b0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0);
        run_add(8'hFF, 8'h00, 1'b1, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0);
        run_add(8'h00, 8'h00, 1'b0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0);

        // Stray start (a=0x11) in RUN cycle 3 must be dropped.
        run_add(8'h23, 8'h45, 1'b1, 0, 0, 1, 0, 8'h00, 8'h00, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("stray_no_done", 16'(done), 16'd0);
            chk("stray_no_busy", 16'(busy), 16'd0);
            chk("stray_sum",     16'(sum),  16'h69);
        end

        // Reset asserted in RUN cycle 4.
        @(negedge clk);
        op_a = 8'hC3; op_b = 8'h5F; op_cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 16'(busy), 16'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_done", 16'(done), 16'd0);
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_done", 16'(done), 16'd0);
            chk("post_rst_busy", 16'(busy), 16'd0);
        end
        run_add(8'h80, 8'h80, 1'b0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0);

        // start held high continuously, new operands presented in each DONE cycle.
        run_add(8'h01, 8'h02, 1'b0, 0, 1, 0, 1, 8'h7F, 8'h01, 1'b0);
        run_add(8'h7F, 8'h01, 1'b0, 1, 1, 0, 1, 8'hA5, 8'h5A, 1'b1);
        run_add(8'hA5, 8'h5A, 1'b1, 1, 1, 0, 0, 8'h00, 8'h00, 1'b0);

        for (int k = 0; k < 6; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run_add(ra, rb, rc, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
